pend_prio_encoder: RTL and testbench
====================================

Name: pend_prio_encoder

Overview:
- Parametrised, registered successor to the 8:3 priority encoders.
- Collects sticky request bits from N sources.
- Emits the index of the selected pending source through a one-entry valid/ready output slot, clearing each request as it is issued.
- Selection mode is compile-time: fixed LSB-first, fixed MSB-first, or round-robin. Used as an interrupt/service-request scheduler in front of shared handlers.

Parameters:
N, 8, number of request sources (N >= 2; need not be a power of 2)
W, $clog2(N), index width (derived, not overridden)
MODE, 0, selection policy: 0 = LSB highest priority, 1 = MSB highest priority, 2 = round-robin

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_in  in  N  request pulses; bit i=1 in a cycle sets pending bit i
clr_all  in  1  synchronous flush of all pending bits and the output slot
out_ready  in  1  consumer accepts out_idx this cycle
out_valid  out  1  out_idx holds a valid issued index
out_idx  out  W  issued source index
pend  out  N  current pending vector (registered)
req_drop  out  1  one-cycle pulse: a req_in bit hit an already-pending bit

Behaviour:
- Reset (rst_n=0, asynchronous): pend=0, out_valid=0, out_idx=0, req_drop=0, rr pointer=0. Outputs are held at these values while rst_n is low.
- Reset mid-operation: an in-flight slot is discarded with no handshake.
- Slot load condition: load = !out_valid || out_ready.
- Selection: combinational over the registered pend only. Same-cycle req_in is never selected.
  - MODE 0: lowest set index.
  - MODE 1: highest set index.
  - MODE 2: first set index scanning upward from ptr, wrapping N-1 -> 0.
- When load and pend != 0:
  - out_idx <= sel, out_valid <= 1.
  - pend[sel] is cleared this edge, because the request moves into the slot.
  - MODE 2 only: ptr <= (sel == N-1) ? 0 : sel+1.
- When load and pend == 0: out_valid <= 0. out_idx keeps its last value.
- When out_valid && !out_ready: out_idx and out_valid are held stable.
- Next pending state: pend_next = (pend & ~clr_sel) | req_in.
  - clr_sel is one-hot of sel on load, otherwise 0.
  - If req_in sets the bit being cleared in the same cycle, req_in wins and the bit stays pending, giving a second service.
  - A request for the index currently in the slot sets pend normally.
- req_drop <= |(req_in & pend & ~clr_sel). This is registered and asserted the cycle after the collision.
- clr_all=1: pend <= 0 and out_valid <= 0, overriding req_in and the load in the same cycle. ptr and out_idx are unchanged. req_drop <= 0.
- Latency: req_in sampled at edge t, pend visible after t, out_valid=1 after edge t+1 (2 cycles from req to valid). With out_ready held at 1, throughput is one index per cycle.
- Indices >= N never appear. For non-power-of-2 N, the wrap is at N-1.

Decomposition:
- Package pend_prio_pkg: MODE_LSB=0, MODE_MSB=1, MODE_RR=2 localparams, plus a function for the index width.
- One sub-module, prio_pick (combinational):
  - Inputs: vec[N], start[W], mode.
  - Outputs: any, sel[W].
  - Implementation: rotate by start, find the lowest set bit (or the highest, for MODE 1), then un-rotate modulo N.
  - Fixed modes tie start to 0.
- The top level holds pend, the slot, ptr and req_drop.

Test Plan:
- MODE 0, N=8, req_in=8'b1010_0100 for one cycle, out_ready=1 -> out_idx 2, 5, 7 on three consecutive valid cycles, then out_valid=0 and pend=0.
- MODE 1, same stimulus -> out_idx 7, 5, 2.
- MODE 2, N=8, req_in=8'h83 held every cycle, out_ready=1 -> steady-state sequence 0, 1, 7, 0, 1, 7. With MODE 0 and the same stimulus, out_idx=0 every cycle (starvation contrast).
- Backpressure: slot holds idx 3, out_ready=0 for 4 cycles, req_in=8'h30 -> out_idx stays 3, pend=8'h30. On release: 3 accepted, then 4, then 5.
- Drop and flush:
  - req_in bit 6 twice while pending -> req_drop=1 for exactly one cycle after the second pulse, and idx 6 is issued once.
  - clr_all together with req_in=8'hFF -> pend=0 and out_valid=0 next cycle.
- Async reset: assert rst_n=0 mid-edge with out_valid=1 and pend=8'h0F -> all outputs 0 immediately. After release, req_in=8'h01 -> out_idx=0, valid 2 cycles later. Repeat with N=5, MODE 2, req=5'b10001 held -> 0, 4, 0, 4.

Source files
------------

// File: rtl/pend_prio_pkg.sv
// Shared selection-mode encodings and index-width helper
// for the pending-request priority encoder.
package pend_prio_pkg;
  localparam int MODE_LSB = 0;
  localparam int MODE_MSB = 1;
  localparam int MODE_RR  = 2;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/prio_pick.sv
// Combinational pick of the first set bit of vec, scanning
// from start upward with wrap at N-1 (downward from N-1 in MSB mode).
module prio_pick
  import pend_prio_pkg::*;
#(
  parameter int N    = 8,
  parameter int MODE = MODE_LSB,
  localparam int W   = idx_w(N)
) (
  input  logic [N-1:0] vec,
  input  logic [W-1:0] start,
  output logic         any,
  output logic [W-1:0] sel
);

  logic [N-1:0] rot;
  logic         found;
  int           j;
  int           pos;
  int           k;

  always_comb begin
    rot   = '0;
    found = 1'b0;
    j     = 0;
    pos   = 0;
    k     = 0;
    for (int i = 0; i < N; i++) begin
      j = i + int'(start);
      if (j >= N) j = j - N;
      rot[i] = vec[j];
    end
    if (MODE == MODE_MSB) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (!found && rot[i]) begin
          pos   = i;
          found = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (!found && rot[i]) begin
          pos   = i;
          found = 1'b1;
        end
      end
    end
    // un-rotate back into source numbering, modulo N
    k = pos + int'(start);
    if (k >= N) k = k - N;
    sel = W'(k);
    any = |vec;
  end

endmodule

// File: rtl/pend_prio_encoder.sv
// Sticky request collector issuing one selected index per
// handshake through a single-entry valid/ready slot.
module pend_prio_encoder
  import pend_prio_pkg::*;
#(
  parameter int N    = 8,
  parameter int MODE = MODE_LSB,
  localparam int W   = idx_w(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req_in,
  input  logic         clr_all,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] pend,
  output logic         req_drop
);

  logic [W-1:0] ptr;
  logic [W-1:0] start;
  logic [W-1:0] sel;
  logic         any;
  logic         load;
  logic         issue;
  logic [N-1:0] clr_sel;

  assign start = (MODE == MODE_RR) ? ptr : '0;

  prio_pick #(
    .N    (N),
    .MODE (MODE)
  ) u_pick (
    .vec   (pend),
    .start (start),
    .any   (any),
    .sel   (sel)
  );

  assign load    = !out_valid || out_ready;
  assign issue   = load && any;
  assign clr_sel = issue ? (N'(1) << sel) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend      <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      req_drop  <= 1'b0;
      ptr       <= '0;
    end else if (clr_all) begin
      pend      <= '0;
      out_valid <= 1'b0;
      req_drop  <= 1'b0;
    end else begin
      // a same-cycle request re-arms the bit being issued
      pend     <= (pend & ~clr_sel) | req_in;
      req_drop <= |(req_in & pend & ~clr_sel);
      if (load) begin
        out_valid <= any;
        if (any) begin
          out_idx <= sel;
          if (MODE == MODE_RR)
            ptr <= (sel == W'(N - 1)) ? '0 : sel + W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_pend_prio_encoder.sv
// Directed bench: LSB/MSB/round-robin instances at N=8 plus a
// round-robin instance at N=5, with hand-computed expectations.
module tb_pend_prio_encoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic [7:0] req_a = '0, req_b = '0, req_c = '0;
  logic [4:0] req_d = '0;
  logic       clr_a = 0, clr_b = 0, clr_c = 0, clr_d = 0;
  logic       rdy_a = 1, rdy_b = 1, rdy_c = 1, rdy_d = 1;
  logic       vld_a, vld_b, vld_c, vld_d;
  logic [2:0] idx_a, idx_b, idx_c, idx_d;
  logic [7:0] pnd_a, pnd_b, pnd_c;
  logic [4:0] pnd_d;
  logic       drp_a, drp_b, drp_c, drp_d;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  pend_prio_encoder #(.N(8), .MODE(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_in(req_a), .clr_all(clr_a),
    .out_ready(rdy_a), .out_valid(vld_a), .out_idx(idx_a),
    .pend(pnd_a), .req_drop(drp_a));

  pend_prio_encoder #(.N(8), .MODE(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_in(req_b), .clr_all(clr_b),
    .out_ready(rdy_b), .out_valid(vld_b), .out_idx(idx_b),
    .pend(pnd_b), .req_drop(drp_b));

  pend_prio_encoder #(.N(8), .MODE(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .req_in(req_c), .clr_all(clr_c),
    .out_ready(rdy_c), .out_valid(vld_c), .out_idx(idx_c),
    .pend(pnd_c), .req_drop(drp_c));

  pend_prio_encoder #(.N(5), .MODE(2)) dut_d (
    .clk(clk), .rst_n(rst_n), .req_in(req_d), .clr_all(clr_d),
    .out_ready(rdy_d), .out_valid(vld_d), .out_idx(idx_d),
    .pend(pnd_d), .req_drop(drp_d));

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #12;
    chk("rst_vld_a", 32'(vld_a), 0);
    chk("rst_idx_a", 32'(idx_a), 0);
    chk("rst_pnd_a", 32'(pnd_a), 0);
    chk("rst_drp_a", 32'(drp_a), 0);
    chk("rst_vld_d", 32'(vld_d), 0);
    rst_n = 1'b1;

    // single burst A4: LSB gives 2,5,7 ; MSB gives 7,5,2
    req_a = 8'hA4; req_b = 8'hA4;
    tick();
    req_a = '0; req_b = '0;
    chk("burst_pnd_a", 32'(pnd_a), 32'hA4);
    chk("burst_vld_a", 32'(vld_a), 0);
    tick();
    chk("lsb_i0", 32'(idx_a), 2); chk("lsb_v0", 32'(vld_a), 1);
    chk("msb_i0", 32'(idx_b), 7); chk("msb_v0", 32'(vld_b), 1);
    chk("lsb_p0", 32'(pnd_a), 32'hA0);
    tick();
    chk("lsb_i1", 32'(idx_a), 5); chk("msb_i1", 32'(idx_b), 5);
    tick();
    chk("lsb_i2", 32'(idx_a), 7); chk("msb_i2", 32'(idx_b), 2);
    chk("lsb_p2", 32'(pnd_a), 0);
    tick();
    chk("lsb_end_v", 32'(vld_a), 0); chk("msb_end_v", 32'(vld_b), 0);
    chk("lsb_end_p", 32'(pnd_a), 0); chk("msb_end_p", 32'(pnd_b), 0);

    // held 83: round-robin rotates, LSB starves upper sources
    req_a = 8'h83; req_c = 8'h83;
    tick();
    for (int r = 0; r < 2; r++) begin
      tick();
      chk("rr_0", 32'(idx_c), 0); chk("starve", 32'(idx_a), 0);
      tick();
      chk("rr_1", 32'(idx_c), 1); chk("starve", 32'(idx_a), 0);
      tick();
      chk("rr_7", 32'(idx_c), 7); chk("starve", 32'(idx_a), 0);
      chk("rr_vld", 32'(vld_c), 1);
    end

    // flush overrides a simultaneous all-ones request
    req_a = 8'hFF; clr_a = 1; req_c = '0; clr_c = 1;
    tick();
    chk("flush_pnd", 32'(pnd_a), 0);
    chk("flush_vld", 32'(vld_a), 0);
    chk("flush_drp", 32'(drp_a), 0);
    chk("flush_vld_c", 32'(vld_c), 0);
    req_a = '0; clr_a = 0; clr_c = 0;

    // backpressure: slot holds 3 while 4,5 queue up
    req_a = 8'h08;
    tick();
    req_a = '0;
    tick();
    chk("bp_load", 32'(idx_a), 3);
    rdy_a = 0; req_a = 8'h30;
    tick();
    req_a = '0;
    chk("bp_hold_i", 32'(idx_a), 3); chk("bp_hold_p", 32'(pnd_a), 32'h30);
    for (int r = 0; r < 3; r++) begin
      tick();
      chk("bp_hold_i", 32'(idx_a), 3);
      chk("bp_hold_v", 32'(vld_a), 1);
      chk("bp_hold_p", 32'(pnd_a), 32'h30);
    end
    rdy_a = 1;
    tick();
    chk("bp_rel_4", 32'(idx_a), 4);
    tick();
    chk("bp_rel_5", 32'(idx_a), 5);
    tick();
    chk("bp_rel_v", 32'(vld_a), 0);

    // drop: bit 6 pulsed twice while pending behind a stalled slot
    rdy_a = 0; req_a = 8'h01;
    tick();
    req_a = '0;
    tick();
    req_a = 8'h40;
    tick();
    req_a = '0;
    tick();
    chk("drop_pre", 32'(drp_a), 0);
    req_a = 8'h40;
    tick();
    req_a = '0;
    chk("drop_hit", 32'(drp_a), 1);
    chk("drop_pnd", 32'(pnd_a), 32'h40);
    tick();
    chk("drop_one", 32'(drp_a), 0);
    rdy_a = 1;
    tick();
    chk("drop_iss6", 32'(idx_a), 6); chk("drop_pnd0", 32'(pnd_a), 0);
    tick();
    chk("drop_once", 32'(vld_a), 0);

    // async reset mid-cycle with slot full and pend 0F
    rdy_a = 0; req_a = 8'h0F;
    tick();
    tick();
    req_a = '0;
    chk("pre_rst_v", 32'(vld_a), 1); chk("pre_rst_p", 32'(pnd_a), 32'h0F);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_vld", 32'(vld_a), 0); chk("arst_idx", 32'(idx_a), 0);
    chk("arst_pnd", 32'(pnd_a), 0); chk("arst_drp", 32'(drp_a), 0);
    tick();
    chk("arst_hold", 32'(vld_a), 0);
    rst_n = 1'b1; rdy_a = 1;
    req_a = 8'h01;
    tick();
    req_a = '0;
    chk("post_v1", 32'(vld_a), 0);
    tick();
    chk("post_v2", 32'(vld_a), 1); chk("post_i", 32'(idx_a), 0);

    // N=5 round-robin wraps at 4
    req_d = 5'b10001;
    tick();
    tick(); chk("n5_0a", 32'(idx_d), 0);
    tick(); chk("n5_4a", 32'(idx_d), 4);
    tick(); chk("n5_0b", 32'(idx_d), 0);
    tick(); chk("n5_4b", 32'(idx_d), 4);
    chk("n5_vld", 32'(vld_d), 1);
    req_d = '0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nerr);
    $finish;
  end

endmodule
